// File: rtl/fifo_pkg.sv
// Shared FIFO sizing helpers: depth from address width, pointer width, threshold legality.
// Used by the status controller and its sibling FIFO blocks.
package fifo_pkg;

    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    // One extra MSB distinguishes full from empty when the low bits match.
    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

    function automatic bit af_level_legal(input int addr_width, input int af_level);
        return (af_level >= 1) && (af_level <= fifo_depth(addr_width));
    endfunction

    function automatic bit ae_level_legal(input int addr_width, input int ae_level);
        return (ae_level >= 0) && (ae_level <= fifo_depth(addr_width) - 1);
    endfunction

endpackage

// File: rtl/fifo_flag_calc.sv
// Occupancy and status flags derived from a pair of wrap-bit pointers.
// Latency: purely combinational. Backpressure: none, evaluates whatever pointers it is given.
module fifo_flag_calc
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int AF_LEVEL   = fifo_depth(ADDR_WIDTH) - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic [ADDR_WIDTH:0] next_wr_ptr,
    input  logic [ADDR_WIDTH:0] next_rd_ptr,
    output logic [ADDR_WIDTH:0] next_level,
    output logic                next_empty,
    output logic                next_full,
    output logic                next_almost_empty,
    output logic                next_almost_full
);
    localparam int PW = ptr_width(ADDR_WIDTH);
    localparam logic [PW-1:0] AF_THR = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_THR = PW'(AE_LEVEL);

    logic low_match;

    always_comb begin
        low_match         = (next_wr_ptr[ADDR_WIDTH-1:0] == next_rd_ptr[ADDR_WIDTH-1:0]);
        // Modular subtraction gives the true occupancy across pointer wrap.
        next_level        = next_wr_ptr - next_rd_ptr;
        next_empty        = low_match && (next_wr_ptr[ADDR_WIDTH] == next_rd_ptr[ADDR_WIDTH]);
        next_full         = low_match && (next_wr_ptr[ADDR_WIDTH] != next_rd_ptr[ADDR_WIDTH]);
        next_almost_full  = (next_level >= AF_THR);
        next_almost_empty = (next_level <= AE_THR);
    end

endmodule

// File: rtl/fifo_status_ctrl.sv
// FIFO pointer/status controller: owns wr/rd pointers, drives memory enables, registers flags.
// Latency: accepts are combinational, all other outputs update one edge after the request.
// Backpressure: writes refused while full, reads refused while empty; refusals set sticky errors.
module fifo_status_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int AF_LEVEL   = fifo_depth(ADDR_WIDTH) - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_wr_en,
    input  logic                i_rd_en,
    input  logic                i_clr_err,
    output logic                o_wr_accept,
    output logic                o_rd_accept,
    output logic [ADDR_WIDTH:0] o_wr_address,
    output logic [ADDR_WIDTH:0] o_rd_address,
    output logic [ADDR_WIDTH:0] o_level,
    output logic                o_empty,
    output logic                o_full,
    output logic                o_almost_empty,
    output logic                o_almost_full,
    output logic                o_overflow,
    output logic                o_underflow
);
    localparam int PW = ptr_width(ADDR_WIDTH);

    if (!af_level_legal(ADDR_WIDTH, AF_LEVEL) || !ae_level_legal(ADDR_WIDTH, AE_LEVEL)) begin : g_bad_cfg
        $error("fifo_status_ctrl: AF_LEVEL/AE_LEVEL outside legal range for ADDR_WIDTH");
    end

    logic [PW-1:0] wr_ptr_nxt;
    logic [PW-1:0] rd_ptr_nxt;
    logic [PW-1:0] level_nxt;
    logic          empty_nxt;
    logic          full_nxt;
    logic          almost_empty_nxt;
    logic          almost_full_nxt;
    logic          wr_reject;
    logic          rd_reject;

    // Accept decisions use only the registered flags, so a same-cycle read never frees a full slot.
    assign o_wr_accept = i_wr_en && !o_full;
    assign o_rd_accept = i_rd_en && !o_empty;
    assign wr_reject   = i_wr_en && o_full;
    assign rd_reject   = i_rd_en && o_empty;

    assign wr_ptr_nxt  = o_wr_address + PW'(o_wr_accept);
    assign rd_ptr_nxt  = o_rd_address + PW'(o_rd_accept);

    fifo_flag_calc #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .AF_LEVEL   (AF_LEVEL),
        .AE_LEVEL   (AE_LEVEL)
    ) u_flag_calc (
        .next_wr_ptr       (wr_ptr_nxt),
        .next_rd_ptr       (rd_ptr_nxt),
        .next_level        (level_nxt),
        .next_empty        (empty_nxt),
        .next_full         (full_nxt),
        .next_almost_empty (almost_empty_nxt),
        .next_almost_full  (almost_full_nxt)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_wr_address   <= '0;
            o_rd_address   <= '0;
            o_level        <= '0;
            o_empty        <= 1'b1;
            o_full         <= 1'b0;
            o_almost_empty <= 1'b1;
            o_almost_full  <= 1'b0;
            o_overflow     <= 1'b0;
            o_underflow    <= 1'b0;
        end else begin
            o_wr_address   <= wr_ptr_nxt;
            o_rd_address   <= rd_ptr_nxt;
            o_level        <= level_nxt;
            o_empty        <= empty_nxt;
            o_full         <= full_nxt;
            o_almost_empty <= almost_empty_nxt;
            o_almost_full  <= almost_full_nxt;
            // A fresh rejection outranks a clear in the same cycle.
            o_overflow     <= wr_reject || (o_overflow && !i_clr_err);
            o_underflow    <= rd_reject || (o_underflow && !i_clr_err);
        end
    end

endmodule

// File: tb/tb_fifo_status_ctrl.sv
// Bench for fifo_status_ctrl at ADDR_WIDTH=2, AF_LEVEL=3, AE_LEVEL=1.
// Vector table plus reset, mid-stream reset and wrap sequences; expected state goes through a queue.
module tb_fifo_status_ctrl;
    localparam int AW = 2;

    logic       clk = 1'b0;
    logic       i_rst_n, i_wr_en, i_rd_en, i_clr_err;
    logic       o_wr_accept, o_rd_accept;
    logic [2:0] o_wr_address, o_rd_address, o_level;
    logic       o_empty, o_full, o_almost_empty, o_almost_full, o_overflow, o_underflow;

    always #5 clk = ~clk;

    fifo_status_ctrl #(.ADDR_WIDTH(AW), .AF_LEVEL(3), .AE_LEVEL(1)) dut (
        .i_clk          (clk),
        .i_rst_n        (i_rst_n),
        .i_wr_en        (i_wr_en),
        .i_rd_en        (i_rd_en),
        .i_clr_err      (i_clr_err),
        .o_wr_accept    (o_wr_accept),
        .o_rd_accept    (o_rd_accept),
        .o_wr_address   (o_wr_address),
        .o_rd_address   (o_rd_address),
        .o_level        (o_level),
        .o_empty        (o_empty),
        .o_full         (o_full),
        .o_almost_empty (o_almost_empty),
        .o_almost_full  (o_almost_full),
        .o_overflow     (o_overflow),
        .o_underflow    (o_underflow)
    );

    typedef struct packed {
        logic [2:0] wp, rp, lvl;
        logic       e, f, ae, af, ov, un;
    } st_t;

    typedef struct {
        logic rst_n, wr, rd, clr, wacc, racc;
        st_t  st;
    } vec_t;

    st_t  exp_q[$];
    vec_t vt[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic st_t mk_st(input int wp, rp, lvl, input bit e, f, ae, af, ov, un);
        st_t s;
        s.wp = 3'(wp); s.rp = 3'(rp); s.lvl = 3'(lvl);
        s.e = e; s.f = f; s.ae = ae; s.af = af; s.ov = ov; s.un = un;
        return s;
    endfunction

    function automatic vec_t mk_v(input bit rst_n, wr, rd, clr, wacc, racc, input st_t s);
        vec_t v;
        v.rst_n = rst_n; v.wr = wr; v.rd = rd; v.clr = clr;
        v.wacc = wacc; v.racc = racc; v.st = s;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Drive at negedge, check accepts mid-cycle, queue expected state, compare after the edge.
    task automatic step(input bit rst_n, wr, rd, clr, chk_acc, wacc, racc,
                        input st_t e, input string tag);
        st_t got;
        @(negedge clk);
        i_rst_n = rst_n; i_wr_en = wr; i_rd_en = rd; i_clr_err = clr;
        #1;
        if (chk_acc) begin
            check({tag, " wr_accept"}, 32'(o_wr_accept), 32'(wacc));
            check({tag, " rd_accept"}, 32'(o_rd_accept), 32'(racc));
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = {o_wr_address, o_rd_address, o_level, o_empty, o_full,
               o_almost_empty, o_almost_full, o_overflow, o_underflow};
        check({tag, " state{wp,rp,lvl,e,f,ae,af,ov,un}"}, 32'(got), 32'(exp_q.pop_front()));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        st_t rst_st;
        rst_st = mk_st(0, 0, 0, 1, 0, 1, 0, 0, 0);
        i_rst_n = 1'b0; i_wr_en = 1'b0; i_rd_en = 1'b0; i_clr_err = 1'b0;

        // Fill, overflow and clear, drain, underflow, simultaneous, wrap-while-full.
        vt.push_back(mk_v(1,1,0,0, 1,0, mk_st(1,0,1, 0,0,1,0, 0,0)));
        vt.push_back(mk_v(1,1,0,0, 1,0, mk_st(2,0,2, 0,0,0,0, 0,0)));
        vt.push_back(mk_v(1,1,0,0, 1,0, mk_st(3,0,3, 0,0,0,1, 0,0)));
        vt.push_back(mk_v(1,1,0,0, 1,0, mk_st(4,0,4, 0,1,0,1, 0,0)));
        vt.push_back(mk_v(1,1,0,0, 0,0, mk_st(4,0,4, 0,1,0,1, 1,0)));
        vt.push_back(mk_v(1,0,0,0, 0,0, mk_st(4,0,4, 0,1,0,1, 1,0)));
        vt.push_back(mk_v(1,0,0,1, 0,0, mk_st(4,0,4, 0,1,0,1, 0,0)));
        vt.push_back(mk_v(1,1,0,1, 0,0, mk_st(4,0,4, 0,1,0,1, 1,0)));
        vt.push_back(mk_v(1,0,0,1, 0,0, mk_st(4,0,4, 0,1,0,1, 0,0)));
        vt.push_back(mk_v(1,0,1,0, 0,1, mk_st(4,1,3, 0,0,0,1, 0,0)));
        vt.push_back(mk_v(1,0,1,0, 0,1, mk_st(4,2,2, 0,0,0,0, 0,0)));
        vt.push_back(mk_v(1,1,1,0, 1,1, mk_st(5,3,2, 0,0,0,0, 0,0)));
        vt.push_back(mk_v(1,0,1,0, 0,1, mk_st(5,4,1, 0,0,1,0, 0,0)));
        vt.push_back(mk_v(1,0,1,0, 0,1, mk_st(5,5,0, 1,0,1,0, 0,0)));
        vt.push_back(mk_v(1,0,1,0, 0,0, mk_st(5,5,0, 1,0,1,0, 0,1)));
        vt.push_back(mk_v(1,1,1,0, 1,0, mk_st(6,5,1, 0,0,1,0, 0,1)));
        vt.push_back(mk_v(1,0,0,1, 0,0, mk_st(6,5,1, 0,0,1,0, 0,0)));
        vt.push_back(mk_v(1,0,1,0, 0,1, mk_st(6,6,0, 1,0,1,0, 0,0)));
        vt.push_back(mk_v(1,1,0,0, 1,0, mk_st(7,6,1, 0,0,1,0, 0,0)));
        vt.push_back(mk_v(1,1,0,0, 1,0, mk_st(0,6,2, 0,0,0,0, 0,0)));
        vt.push_back(mk_v(1,1,0,0, 1,0, mk_st(1,6,3, 0,0,0,1, 0,0)));
        vt.push_back(mk_v(1,1,0,0, 1,0, mk_st(2,6,4, 0,1,0,1, 0,0)));
        vt.push_back(mk_v(1,1,1,0, 0,1, mk_st(2,7,3, 0,0,0,1, 1,0)));
        vt.push_back(mk_v(1,0,0,1, 0,0, mk_st(2,7,3, 0,0,0,1, 0,0)));

        // Two reset cycles with random requests.
        for (int i = 0; i < 2; i++)
            step(0, 1'($urandom), 1'($urandom), 1'($urandom), 0, 0, 0, rst_st, $sformatf("reset%0d", i));

        foreach (vt[i])
            step(vt[i].rst_n, vt[i].wr, vt[i].rd, vt[i].clr, 1, vt[i].wacc, vt[i].racc,
                 vt[i].st, $sformatf("vec%0d", i));

        // Reset mid-stream with requests pending discards them.
        step(0, 1, 1, 0, 0, 0, 0, rst_st, "midreset");

        // Interleaved write/read pairs across several pointer wraps.
        for (int k = 0; k < 20; k++) begin
            step(1, 1, 0, 0, 1, 1, 0, mk_st(k + 1, k, 1, 0, 0, 1, 0, 0, 0), $sformatf("wrap_w%0d", k));
            step(1, 0, 1, 0, 1, 0, 1, mk_st(k + 1, k + 1, 0, 1, 0, 1, 0, 0, 0), $sformatf("wrap_r%0d", k));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
